ft601_bus_emulator: RTL and testbench

Synthesizable model of the FT601 chip side of the 245-synchronous FIFO bus, the responder to our FPGA-side FT601 controller. It holds a host-to-FPGA RX FIFO and an FPGA-to-host TX FIFO, drives the empty and full flags, and drives the data and byte-enable bus during reads. It samples the bus during writes and flags protocol violations. It is used in simulation and in FPGA loopback builds without a real FT601; a host-side stream port stands in for the USB host.

---
 rtl/ft601_pkg.sv | 15 +
 rtl/ft601_fifo.sv | 72 +++++++
 rtl/ft601_bus_emulator.sv | 148 ++++++++++++++
 tb/tb_ft601_bus_emulator.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft601_pkg.sv
// Shared FT601 bus definitions: bus-phase encoding and default bus widths,
// common to the FPGA-side controller and this chip-side emulator.
package ft601_pkg;

  localparam int FT_DATA_W = 32;
  localparam int FT_BE_W   = 4;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_TURNAROUND,
    PH_READ,
    PH_WRITE
  } bus_phase_e;

endpackage

// File: rtl/ft601_fifo.sv
// First-word-fall-through synchronous FIFO; rdata_o shows the head word with
// zero latency. DEPTH must be a power of two so pointers wrap naturally.
module ft601_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ft601_bus_emulator.sv
// FT601 chip-side responder for the 245-synchronous FIFO bus.
// state | meaning: IDLE bus quiet | TURNAROUND outen granted, read may start | READ reading | WRITE FPGA writing
module ft601_bus_emulator
  import ft601_pkg::*;
#(
  parameter int DATA_W   = FT_DATA_W,
  parameter int BE_W     = FT_BE_W,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        usb_wren_l,
  input  logic                        usb_rden_l,
  input  logic                        usb_outen_l,
  input  logic                        usb_rst_l,
  output logic                        usb_tx_full,
  output logic                        usb_rx_empty,
  inout  wire  [DATA_W-1:0]           data,
  inout  wire  [BE_W-1:0]             be,
  input  logic [DATA_W-1:0]           host_wr_data,
  input  logic [BE_W-1:0]             host_wr_be,
  input  logic                        host_wr_valid,
  output logic                        host_wr_ready,
  output logic [DATA_W-1:0]           host_rd_data,
  output logic [BE_W-1:0]             host_rd_be,
  output logic                        host_rd_valid,
  input  logic                        host_rd_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic [$clog2(TX_DEPTH):0]   tx_count,
  output logic                        overflow_err,
  output logic                        underrun_err,
  output logic                        protocol_err
);

  localparam int W = DATA_W + BE_W;

  bus_phase_e state_q, state_d;
  logic       overflow_q, overflow_d;
  logic       underrun_q, underrun_d;
  logic       protocol_q, protocol_d;
  logic       proto_viol, bus_conflict, bus_drive, clr;
  logic       rx_push, rx_pop, rx_full;
  logic       tx_push, tx_pop, tx_empty;
  logic [W-1:0] rx_head, tx_head, bus_word;

  assign clr          = !usb_rst_l;
  assign bus_conflict = !usb_outen_l && !usb_wren_l;

  assign host_wr_ready = !rx_full;
  assign host_rd_valid = !tx_empty;
  assign host_rd_data  = tx_head[DATA_W-1:0];
  assign host_rd_be    = tx_head[W-1:DATA_W];

  assign rx_push = host_wr_valid && host_wr_ready;
  assign rx_pop  = !usb_rden_l && !usb_outen_l && !usb_rx_empty;
  assign tx_push = !usb_wren_l && usb_outen_l && !usb_tx_full;
  assign tx_pop  = host_rd_valid && host_rd_ready;

  ft601_fifo #(.WIDTH(W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .push_i  (rx_push),
    .wdata_i ({host_wr_be, host_wr_data}),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (usb_rx_empty),
    .count_o (rx_count)
  );

  ft601_fifo #(.WIDTH(W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .push_i  (tx_push),
    .wdata_i ({be, data}),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (usb_tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  // Gated by rst so the bus lets go the instant reset asserts, not at the next edge.
  assign bus_drive = !rst && !usb_outen_l && usb_wren_l;
  assign bus_word  = usb_rx_empty ? '0 : rx_head;
  assign data      = bus_drive ? bus_word[DATA_W-1:0] : 'z;
  assign be        = bus_drive ? bus_word[W-1:DATA_W] : 'z;

  always_comb begin
    state_d    = state_q;
    proto_viol = bus_conflict;
    unique case (state_q)
      PH_IDLE: begin
        if (!usb_rden_l) proto_viol = 1'b1;
        if (!usb_outen_l)     state_d = PH_TURNAROUND;
        else if (!usb_wren_l) state_d = PH_WRITE;
      end
      PH_TURNAROUND: begin
        if (!usb_wren_l) proto_viol = 1'b1;
        if (!usb_rden_l)      state_d = PH_READ;
        else if (usb_outen_l) state_d = PH_IDLE;
      end
      PH_READ: begin
        if (!usb_wren_l) proto_viol = 1'b1;
        if (usb_outen_l) state_d = PH_IDLE;
      end
      PH_WRITE: begin
        if (!usb_rden_l) proto_viol = 1'b1;
        if (usb_wren_l)        state_d = PH_IDLE;
        else if (!usb_outen_l) state_d = PH_TURNAROUND;
      end
      default: state_d = PH_IDLE;
    endcase

    overflow_d = overflow_q || (!usb_wren_l && usb_tx_full);
    underrun_d = underrun_q || (!usb_rden_l && usb_rx_empty);
    protocol_d = protocol_q || proto_viol;

    if (clr) begin
      state_d    = PH_IDLE;
      overflow_d = 1'b0;
      underrun_d = 1'b0;
      protocol_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PH_IDLE;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
      protocol_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
      protocol_q <= protocol_d;
    end
  end

  assign overflow_err = overflow_q;
  assign underrun_err = underrun_q;
  assign protocol_err = protocol_q;

endmodule

// File: tb/tb_ft601_bus_emulator.sv
// Scoreboard bench for ft601_bus_emulator: stimulus queues expected words,
// a negedge monitor pops and compares whenever a read or host pop is presented.
module tb_ft601_bus_emulator;

  localparam int DATA_W   = 32;
  localparam int BE_W     = 4;
  localparam int RX_DEPTH = 16;
  localparam int TX_DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic usb_wren_l, usb_rden_l, usb_outen_l, usb_rst_l;
  logic usb_tx_full, usb_rx_empty;
  wire  [DATA_W-1:0] data;
  wire  [BE_W-1:0]   be;
  logic [DATA_W-1:0] host_wr_data;
  logic [BE_W-1:0]   host_wr_be;
  logic              host_wr_valid, host_wr_ready;
  logic [DATA_W-1:0] host_rd_data;
  logic [BE_W-1:0]   host_rd_be;
  logic              host_rd_valid, host_rd_ready;
  logic [4:0]        rx_count, tx_count;
  logic              overflow_err, underrun_err, protocol_err;

  logic              drv_en;
  logic [DATA_W-1:0] data_drv;
  logic [BE_W-1:0]   be_drv;

  // Released bus reads back as all ones, distinguishable from the driven-zero empty case.
  pullup pu_data (data);
  pullup pu_be (be);
  assign data = drv_en ? data_drv : 'z;
  assign be   = drv_en ? be_drv : 'z;

  always #5 clk = ~clk;

  ft601_bus_emulator #(
    .DATA_W(DATA_W), .BE_W(BE_W), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .usb_wren_l(usb_wren_l), .usb_rden_l(usb_rden_l), .usb_outen_l(usb_outen_l),
    .usb_rst_l(usb_rst_l), .usb_tx_full(usb_tx_full), .usb_rx_empty(usb_rx_empty),
    .data(data), .be(be),
    .host_wr_data(host_wr_data), .host_wr_be(host_wr_be),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_rd_data(host_rd_data), .host_rd_be(host_rd_be),
    .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
    .rx_count(rx_count), .tx_count(tx_count),
    .overflow_err(overflow_err), .underrun_err(underrun_err), .protocol_err(protocol_err)
  );

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_rx_q[$];
  logic [35:0] exp_tx_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && usb_rst_l) begin
      if (!usb_rden_l && !usb_outen_l && usb_wren_l) begin
        if (exp_rx_q.size() > 0) begin
          chk("rx_word", {be, data}, exp_rx_q[0]);
          void'(exp_rx_q.pop_front());
        end else begin
          chk("rx_empty_bus", {be, data}, 64'h0);
        end
      end
      if (host_rd_ready) begin
        if (exp_tx_q.size() > 0) begin
          chk("tx_valid", host_rd_valid, 1);
          chk("tx_word", {host_rd_be, host_rd_data}, exp_tx_q[0]);
          void'(exp_tx_q.pop_front());
        end else begin
          chk("tx_valid_empty", host_rd_valid, 0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    usb_wren_l    = 1'b1;
    usb_rden_l    = 1'b1;
    usb_outen_l   = 1'b1;
    host_wr_valid = 1'b0;
    host_rd_ready = 1'b0;
    drv_en        = 1'b0;
  endtask

  task automatic host_push(input logic [31:0] w, input logic [3:0] b);
    host_wr_data  = w;
    host_wr_be    = b;
    host_wr_valid = 1'b1;
    exp_rx_q.push_back({b, w});
    step();
    host_wr_valid = 1'b0;
  endtask

  task automatic fpga_write(input logic [31:0] w);
    drv_en      = 1'b1;
    data_drv    = w;
    be_drv      = 4'hF;
    usb_wren_l  = 1'b0;
    usb_outen_l = 1'b1;
    if (exp_tx_q.size() < TX_DEPTH) exp_tx_q.push_back({4'hF, w});
    step();
  endtask

  task automatic chip_reset();
    usb_rst_l = 1'b0;
    step();
    usb_rst_l = 1'b1;
    exp_rx_q.delete();
    exp_tx_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    usb_rst_l = 1'b1;
    host_wr_data = '0;
    host_wr_be = '0;
    data_drv = '0;
    be_drv = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();

    chk("reset_rx_count", rx_count, 0);
    chk("reset_tx_count", tx_count, 0);
    chk("reset_rx_empty", usb_rx_empty, 1);
    chk("reset_tx_full", usb_tx_full, 0);
    chk("reset_wr_ready", host_wr_ready, 1);
    chk("reset_rd_valid", host_rd_valid, 0);
    chk("reset_errs", {overflow_err, underrun_err, protocol_err}, 0);
    chk("reset_bus", {be, data}, 36'hF_FFFF_FFFF);

    // Basic three-word read with a proper turnaround cycle
    host_push(32'hA5A5_0001, 4'hF);
    host_push(32'hA5A5_0002, 4'hF);
    host_push(32'hA5A5_0003, 4'hF);
    chk("t1_rx_count", rx_count, 3);
    usb_outen_l = 1'b0;
    #1 chk("t1_turnaround_bus", {be, data}, {4'hF, 32'hA5A5_0001});
    step();
    usb_rden_l = 1'b0;
    repeat (3) step();
    idle();
    chk("t1_rx_empty", usb_rx_empty, 1);
    chk("t1_errs", {overflow_err, underrun_err, protocol_err}, 0);
    step();

    // Fill TX, overflow, then host drains
    for (int i = 0; i < 16; i++) fpga_write(32'hC0DE_0000 + 32'(i));
    chk("t2_tx_full", usb_tx_full, 1);
    chk("t2_tx_count16", tx_count, 16);
    chk("t2_no_overflow_yet", overflow_err, 0);
    fpga_write(32'hDEAD_BEEF);
    idle();
    chk("t2_overflow", overflow_err, 1);
    chk("t2_tx_count_hold", tx_count, 16);
    host_rd_ready = 1'b1;
    repeat (16) step();
    host_rd_ready = 1'b0;
    chk("t2_tx_drained", tx_count, 0);
    chk("t2_rd_valid_low", host_rd_valid, 0);

    // Read straight from IDLE, then read while empty
    chip_reset();
    chk("t3_cleared", {overflow_err, underrun_err, protocol_err}, 0);
    host_push(32'h1234_5678, 4'h3);
    usb_outen_l = 1'b0;
    usb_rden_l  = 1'b0;
    step();
    idle();
    chk("t3_protocol", protocol_err, 1);
    chk("t3_popped", rx_count, 0);
    chk("t3_no_underrun", underrun_err, 0);
    step();
    usb_outen_l = 1'b0;
    step();
    usb_rden_l = 1'b0;
    step();
    idle();
    chk("t3_underrun", underrun_err, 1);
    step();

    // outen and wren together: bus released, protocol error
    chip_reset();
    usb_outen_l = 1'b0;
    usb_wren_l  = 1'b0;
    #1 chk("t4_bus_released", {be, data}, 36'hF_FFFF_FFFF);
    step();
    idle();
    chk("t4_protocol", protocol_err, 1);
    chk("t4_no_tx_push", tx_count, 0);

    // Steady-state push+pop at 15 deep; 55 words total wrap the pointers
    chip_reset();
    for (int k = 0; k < 15; k++) host_push(32'hB000_0000 + 32'(k), 4'(k + 1));
    chk("t5_rx_count15", rx_count, 15);
    usb_outen_l = 1'b0;
    step();
    for (int k = 15; k < 55; k++) begin
      usb_rden_l    = 1'b0;
      host_wr_data  = 32'hB000_0000 + 32'(k);
      host_wr_be    = 4'(k + 1);
      host_wr_valid = 1'b1;
      exp_rx_q.push_back({4'(k + 1), 32'hB000_0000 + 32'(k)});
      step();
      chk("t5_rx_count_steady", rx_count, 15);
    end
    host_wr_valid = 1'b0;
    repeat (15) step();
    idle();
    chk("t5_rx_empty", usb_rx_empty, 1);
    chk("t5_protocol_clean", protocol_err, 0);
    step();

    // RX full boundary, then sync chip reset mid-transfer
    for (int k = 0; k < 16; k++) host_push(32'h5A5A_0000 + 32'(k), 4'hF);
    chk("t6_rx_count16", rx_count, 16);
    chk("t6_wr_ready_low", host_wr_ready, 0);
    host_wr_data  = 32'hFFFF_0000;
    host_wr_valid = 1'b1;
    step();
    host_wr_valid = 1'b0;
    chk("t6_rx_count_hold", rx_count, 16);
    fpga_write(32'h0000_00C1);
    fpga_write(32'h0000_00C2);
    idle();
    chk("t6_tx_count2", tx_count, 2);
    usb_outen_l = 1'b0;
    usb_wren_l  = 1'b0;
    step();
    idle();
    chk("t6_protocol", protocol_err, 1);
    usb_outen_l = 1'b0;
    step();
    usb_rden_l = 1'b0;
    step();
    idle();
    chk("t6_rx_count15", rx_count, 15);
    usb_rst_l     = 1'b0;
    host_wr_data  = 32'h0BAD_0BAD;
    host_wr_be    = 4'hF;
    host_wr_valid = 1'b1;
    step();
    usb_rst_l     = 1'b1;
    host_wr_valid = 1'b0;
    exp_rx_q.delete();
    exp_tx_q.delete();
    chk("t6_sync_rx_count", rx_count, 0);
    chk("t6_sync_tx_count", tx_count, 0);
    chk("t6_sync_flags", {usb_rx_empty, usb_tx_full, host_wr_ready, host_rd_valid}, 4'b1010);
    chk("t6_sync_errs", {overflow_err, underrun_err, protocol_err}, 0);

    // Async rst pulse between edges while the bus is being driven
    host_push(32'h7777_0001, 4'hF);
    host_push(32'h7777_0002, 4'hF);
    fpga_write(32'h0000_00D1);
    idle();
    usb_outen_l = 1'b0;
    usb_wren_l  = 1'b0;
    step();
    usb_wren_l = 1'b1;
    #1 chk("t7_bus_driven", {be, data}, {4'hF, 32'h7777_0001});
    chk("t7_protocol_set", protocol_err, 1);
    #1 rst = 1'b1;
    #1;
    chk("t7_async_bus", {be, data}, 36'hF_FFFF_FFFF);
    chk("t7_async_counts", {rx_count, tx_count}, 0);
    chk("t7_async_flags", {usb_rx_empty, usb_tx_full, host_wr_ready, host_rd_valid}, 4'b1010);
    chk("t7_async_errs", {overflow_err, underrun_err, protocol_err}, 0);
    #1 rst = 1'b0;
    exp_rx_q.delete();
    exp_tx_q.delete();
    idle();
    step();
    chk("t7_post_rx_count", rx_count, 0);

    chk("final_rx_queue_empty", exp_rx_q.size(), 0);
    chk("final_tx_queue_empty", exp_tx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
